// File: rtl/onchip_mem_copier_pkg.sv
// Shared definitions for the on-chip memory copier: op codes, FSM states, default widths.
// The CHECKSUM op is present only when ONCHIP_MEM_COPIER_CHECKSUM_EN is defined.
package onchip_mem_copier_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 13;

    localparam logic [1:0] OP_FILL     = 2'd0;
    localparam logic [1:0] OP_COPY     = 2'd1;
    localparam logic [1:0] OP_CHECKSUM = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_CP_RD   = 3'd2,
        ST_CP_WR   = 3'd3,
        ST_CK_RD   = 3'd4,
        ST_CK_TAIL = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    function automatic logic op_supported(input logic [1:0] op);
`ifdef ONCHIP_MEM_COPIER_CHECKSUM_EN
        return op != OP_RSVD;
`else
        return (op == OP_FILL) || (op == OP_COPY);
`endif
    endfunction

endpackage

// File: rtl/onchip_mem_copier_if.sv
// Command port, Avalon-MM s1 master signals and status of the memory copier.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; no queueing while busy.
interface onchip_mem_copier_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_W-1:0]     cmd_src;
    logic [ADDR_W-1:0]     cmd_dst;
    logic [LEN_W-1:0]      cmd_len;
    logic [DATA_W-1:0]     cmd_pattern;
    logic [DATA_W/8-1:0]   cmd_byteen;

    logic [ADDR_W-1:0]     m_address;
    logic [DATA_W/8-1:0]   m_byteenable;
    logic                  m_chipselect;
    logic                  m_write;
    logic [DATA_W-1:0]     m_writedata;
    logic [DATA_W-1:0]     m_readdata;
    logic                  m_clken;

    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_W-1:0]     checksum;
    logic [2:0]            dbg_state;

    modport master (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_pattern, cmd_byteen, m_readdata,
        output cmd_ready, m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output busy, done, err, checksum, dbg_state
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_pattern, cmd_byteen, m_readdata,
        input  cmd_ready, m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  busy, done, err, checksum, dbg_state
    );
endinterface

// File: rtl/onchip_mem_copier_addr_ctr.sv
// Loadable word-address counter with remaining-word count; address wraps modulo 2^ADDR_W.
module onchip_mem_copier_addr_ctr #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = addr_i;
            cnt_d  = len_i;
        end else if (step_i) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == LEN_W'(1));
endmodule

// File: rtl/onchip_mem_copier.sv
// Fill / copy / checksum engine driving a 1-cycle-latency single-port on-chip memory.
// CHECKSUM support is compiled in with ONCHIP_MEM_COPIER_CHECKSUM_EN.
module onchip_mem_copier
    import onchip_mem_copier_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic clk,
    input  logic reset_n,
    onchip_mem_copier_if.master bus
);
    localparam int BE_W = DATA_W / 8;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [BE_W-1:0]   byteen_q, byteen_d;
    logic              err_q, err_d;
    logic              accept, op_ok, load;
    logic              src_step, dst_step, src_last, dst_last;
    logic [ADDR_W-1:0] src_addr, dst_addr;

    logic              cs, wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;

    // Ready is gated by reset_n so it reads 0 for the whole time reset is held.
    assign bus.cmd_ready = (state_q == ST_IDLE) && reset_n;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign op_ok         = op_supported(bus.cmd_op);
    assign load          = accept && op_ok;

    onchip_mem_copier_addr_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_src_ctr (
        .clk_i (clk), .rst_ni(reset_n), .load_i(load), .addr_i(bus.cmd_src),
        .len_i (bus.cmd_len), .step_i(src_step), .addr_o(src_addr), .last_o(src_last)
    );

    onchip_mem_copier_addr_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dst_ctr (
        .clk_i (clk), .rst_ni(reset_n), .load_i(load), .addr_i(bus.cmd_dst),
        .len_i (bus.cmd_len), .step_i(dst_step), .addr_o(dst_addr), .last_o(dst_last)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = load ? bus.cmd_pattern : pattern_q;
        byteen_d  = load ? bus.cmd_byteen : byteen_q;
        err_d     = accept && !op_ok;
        src_step  = 1'b0;
        dst_step  = 1'b0;
        cs        = 1'b0;
        wr        = 1'b0;
        addr      = '0;
        be        = '0;
        wdata     = '0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    if (bus.cmd_len == '0)            state_d = ST_DONE;
                    else if (bus.cmd_op == OP_FILL)   state_d = ST_FILL;
                    else if (bus.cmd_op == OP_COPY)   state_d = ST_CP_RD;
                    else                              state_d = ST_CK_RD;
                end
            end
            ST_FILL: begin
                cs       = 1'b1;
                wr       = 1'b1;
                addr     = dst_addr;
                be       = byteen_q;
                wdata    = pattern_q;
                dst_step = 1'b1;
                if (dst_last) state_d = ST_DONE;
            end
            ST_CP_RD: begin
                cs       = 1'b1;
                addr     = src_addr;
                be       = '1;
                src_step = 1'b1;
                state_d  = ST_CP_WR;
            end
            ST_CP_WR: begin
                // Read data arrives this cycle and goes straight back out as write data.
                cs       = 1'b1;
                wr       = 1'b1;
                addr     = dst_addr;
                be       = '1;
                wdata    = bus.m_readdata;
                dst_step = 1'b1;
                state_d  = dst_last ? ST_DONE : ST_CP_RD;
            end
            ST_CK_RD: begin
                cs       = 1'b1;
                addr     = src_addr;
                be       = '1;
                src_step = 1'b1;
                if (src_last) state_d = ST_CK_TAIL;
            end
            ST_CK_TAIL: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            byteen_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            byteen_q  <= byteen_d;
            err_q     <= err_d;
        end
    end

`ifdef ONCHIP_MEM_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ck_pend_q, ck_pend_d;

    // ck_pend marks the cycle in which the previous CK_RD read data is on m_readdata.
    always_comb begin
        ck_pend_d = (state_q == ST_CK_RD);
        acc_d     = acc_q;
        if (load && (bus.cmd_op == OP_CHECKSUM)) acc_d = '0;
        else if (ck_pend_q)                      acc_d = acc_q + bus.m_readdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            ck_pend_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ck_pend_q <= ck_pend_d;
        end
    end

    assign bus.checksum = acc_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.m_chipselect = cs;
    assign bus.m_write      = wr;
    assign bus.m_address    = addr;
    assign bus.m_byteenable = be;
    assign bus.m_writedata  = wdata;
    assign bus.m_clken      = 1'b1;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.err          = err_q;
    assign bus.dbg_state    = state_q;
endmodule
